// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler.
// FSM state encoding, feedback entry layout and default widths.
package bp_pkg;

   localparam int ADDR_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      SETTLE = 2'd2
   } bp_state_t;

   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] pc;
      logic                      result;
   } bp_fb_entry_t;

endpackage

// File: rtl/bp_fb_fifo.sv
// Feedback queue: holds committed {pc, result} entries awaiting update.
// Ports: clk/rst_n, push/din, pop, head, full, empty, count.
module bp_fb_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   parameter int PW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count
);
   import bp_pkg::*;

   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers are exactly PW bits, so wrap is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates fetch lookups and queued ROB updates into the predictor.
// Ports: Sys_* control, IFPA/PAIF fetch, ROBPA/PAROB commit, PAPD/PDPA predictor.
module bp_update_scheduler #(
   parameter int ADDR_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 8,
   parameter int PTR_WIDTH    = 3,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  Sys_clk,
   input  logic                  Sys_rst,
   input  logic                  Sys_rdy,
   input  logic                  IFPA_predict_en,
   input  logic [ADDR_WIDTH-1:0] IFPA_pc,
   output logic                  PAIF_predict_valid,
   output logic                  PAIF_predict_result,
   output logic                  PAIF_stall,
   input  logic                  ROBPA_feedback_en,
   input  logic [ADDR_WIDTH-1:0] ROBPA_feedback_pc,
   input  logic                  ROBPA_branch_result,
   output logic                  PAROB_full,
   output logic                  PAPD_predict_en,
   output logic [ADDR_WIDTH-1:0] PAPD_pc,
   input  logic                  PDPA_predict_result,
   output logic                  PAPD_feedback_en,
   output logic [ADDR_WIDTH-1:0] PAPD_feedback_pc,
   output logic                  PAPD_branch_result
);
   import bp_pkg::*;

   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

   bp_state_t             state;
   logic [3:0]            starve_cnt;
   logic [PTR_WIDTH:0]    count;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   head;
   logic                  push;
   logic                  pop;
   logic                  in_drain;
   logic                  force_drain;
   logic                  drain_go;

   assign in_drain = (state == DRAIN);

   // A full queue refuses the offer even if this cycle also pops.
   assign push = Sys_rdy & ROBPA_feedback_en & ~full;
   assign pop  = Sys_rdy & in_drain;

   assign force_drain = (starve_cnt == LIMIT_C) | full;
   assign drain_go    = Sys_rdy & ~empty & ~in_drain &
                        (~IFPA_predict_en | force_drain);

   bp_fb_fifo #(
      .WIDTH (ADDR_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .PW    (PTR_WIDTH)
   ) u_fifo (
      .clk   (Sys_clk),
      .rst_n (Sys_rst),
      .push  (push),
      .din   ({ROBPA_feedback_pc, ROBPA_branch_result}),
      .pop   (pop),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // DRAIN is never entered back-to-back: SETTLE forces a low cycle
   // on the update strobe between pulses.
   always_ff @(posedge Sys_clk or negedge Sys_rst) begin
      if (!Sys_rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
      end else if (Sys_rdy) begin
         unique case (state)
            IDLE, SETTLE: state <= drain_go ? DRAIN : IDLE;
            DRAIN:        state <= SETTLE;
            default:      state <= IDLE;
         endcase
         if (empty || drain_go)
            starve_cnt <= '0;
         else if (IFPA_predict_en && !in_drain && starve_cnt != LIMIT_C)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign PAPD_feedback_en   = in_drain;
   assign PAPD_feedback_pc   = head[ADDR_WIDTH:1];
   assign PAPD_branch_result = head[0];

   assign PAPD_predict_en     = IFPA_predict_en & Sys_rdy & ~in_drain;
   assign PAPD_pc             = IFPA_pc;
   assign PAIF_predict_valid  = PAPD_predict_en;
   assign PAIF_predict_result = PDPA_predict_result;
   assign PAIF_stall          = IFPA_predict_en & (in_drain | ~Sys_rdy);
   assign PAROB_full          = full;

   logic unused_ok;
   assign unused_ok = ^count;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized scoreboard bench for bp_update_scheduler.
// A queue-based reference model predicts every cycle's outputs.
module tb_bp_update_scheduler;

   localparam int DEPTH = 8;
   localparam int LIMIT = 4;

   logic        clk = 0;
   logic        rst = 0;
   logic        rdy = 0;
   logic        pe = 0;
   logic [31:0] ipc = '0;
   logic        pv, pres, stall;
   logic        fe = 0;
   logic [31:0] fpc = '0;
   logic        fres = 0;
   logic        full;
   logic        pden;
   logic [31:0] pdpc;
   logic        pdres = 0;
   logic        fben;
   logic [31:0] fbpc;
   logic        fbres;

   bp_update_scheduler #(
      .ADDR_WIDTH   (32),
      .FIFO_DEPTH   (DEPTH),
      .PTR_WIDTH    (3),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .Sys_clk             (clk),
      .Sys_rst             (rst),
      .Sys_rdy             (rdy),
      .IFPA_predict_en     (pe),
      .IFPA_pc             (ipc),
      .PAIF_predict_valid  (pv),
      .PAIF_predict_result (pres),
      .PAIF_stall          (stall),
      .ROBPA_feedback_en   (fe),
      .ROBPA_feedback_pc   (fpc),
      .ROBPA_branch_result (fres),
      .PAROB_full          (full),
      .PAPD_predict_en     (pden),
      .PAPD_pc             (pdpc),
      .PDPA_predict_result (pdres),
      .PAPD_feedback_en    (fben),
      .PAPD_feedback_pc    (fbpc),
      .PAPD_branch_result  (fbres)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      bit          res;
   } ent_t;

   typedef struct {
      int          cyc;
      bit          rdy;
      bit          full;
      bit          fben;
      logic [31:0] fbpc;
      bit          fbres;
      bit          pen;
      bit          pres;
      bit          stall;
      logic [31:0] pc;
   } exp_t;

   ent_t mq[$];
   exp_t exp_q[$];
   bit   m_drain = 0;
   int   m_starve = 0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   function automatic void chk(string n, int c,
                               logic [31:0] a, logic [31:0] x);
      checks++;
      if (a !== x) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", n, c, a, x);
      end
   endfunction

   // Model: the head entry is presented in an update cycle; after
   // one, the next cycle never updates. An update is taken when work
   // is queued and fetch is idle, or fetch has been held off LIMIT
   // times, or the queue is full.
   task automatic do_cycle(input bit r, input bit p, input bit f);
      exp_t e;
      bit   go;
      bit   mfull;
      @(posedge clk);
      #1;
      cyc++;
      rdy   = r;
      pe    = p;
      ipc   = $urandom;
      fe    = f;
      fpc   = $urandom;
      fres  = 1'($urandom_range(0, 1));
      pdres = 1'($urandom_range(0, 1));
      mfull = (mq.size() == DEPTH);
      e.cyc   = cyc;
      e.rdy   = r;
      e.full  = mfull;
      e.fben  = m_drain;
      e.fbpc  = m_drain ? mq[0].pc : '0;
      e.fbres = m_drain ? mq[0].res : 1'b0;
      e.pen   = r && p && !m_drain;
      e.pres  = pdres;
      e.stall = p && m_drain;
      e.pc    = ipc;
      exp_q.push_back(e);
      if (r) begin
         go = !m_drain && mq.size() != 0 &&
              (!p || m_starve == LIMIT || mfull);
         if (mq.size() == 0 || go)
            m_starve = 0;
         else if (p && !m_drain && m_starve < LIMIT)
            m_starve++;
         if (m_drain) void'(mq.pop_front());
         if (f && !mfull) mq.push_back('{fpc, fres});
         m_drain = go;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("full", e.cyc, 32'(full), 32'(e.full));
            chk("fb_en", e.cyc, 32'(fben), 32'(e.fben));
            if (e.fben) begin
               chk("fb_pc", e.cyc, fbpc, e.fbpc);
               chk("fb_res", e.cyc, 32'(fbres), 32'(e.fbres));
            end
            chk("pd_en", e.cyc, 32'(pden), 32'(e.pen));
            chk("pred_valid", e.cyc, 32'(pv), 32'(e.pen));
            if (e.pen) begin
               chk("pd_pc", e.cyc, pdpc, e.pc);
               chk("pred_res", e.cyc, 32'(pres), 32'(e.pres));
            end
            if (e.rdy)
               chk("stall", e.cyc, 32'(stall), 32'(e.stall));
         end
      end
   end

   initial begin : stim
      int ph;
      bit p;
      bit f;
      bit r;
      int n;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_full", 0, 32'(full), 32'd0);
      chk("rst_fb_en", 0, 32'(fben), 32'd0);
      chk("rst_pd_en", 0, 32'(pden), 32'd0);
      @(posedge clk);
      #1 rst = 1;

      // Directed: three pushes with fetch idle, then drain out.
      for (int i = 0; i < 3; i++) do_cycle(1, 0, 1);
      repeat (8) do_cycle(1, 0, 0);
      // Directed: one entry queued, fetch continuously requesting.
      do_cycle(1, 1, 1);
      repeat (10) do_cycle(1, 1, 0);
      // Directed: fill while fetch busy, keep offering.
      repeat (14) do_cycle(1, 1, 1);
      // Directed: drain with Sys_rdy dropping for 3 cycles.
      n = 0;
      while (!m_drain && n < 20) begin
         do_cycle(1, 1, 0);
         n++;
      end
      repeat (3) do_cycle(0, 1, 1);
      repeat (6) do_cycle(1, 0, 0);

      // Randomized phases with different traffic mixes.
      for (int i = 0; i < 1600; i++) begin
         ph = (i / 200) % 4;
         r  = ($urandom_range(0, 9) != 0);
         unique case (ph)
            0: begin p = ($urandom_range(0, 4) == 0); f = $urandom_range(0, 1) == 1; end
            1: begin p = 1'b1; f = ($urandom_range(0, 2) == 0); end
            2: begin p = ($urandom_range(0, 9) != 0); f = ($urandom_range(0, 9) != 0); end
            default: begin p = 1'b0; f = ($urandom_range(0, 4) == 0); end
         endcase
         do_cycle(r, p, f);
      end

      // Reset in the middle of a drain with several entries queued.
      repeat (12) do_cycle(1, 1, 1);
      n = 0;
      while (!(m_drain && mq.size() >= 3) && n < 60) begin
         do_cycle(1, 1, 0);
         n++;
      end
      chk("rst_setup", cyc, 32'(m_drain && mq.size() >= 3), 32'd1);
      @(posedge clk);
      #1 rst = 0;
      fe = 0;
      pe = 0;
      #1;
      chk("midrst_fb_en", cyc, 32'(fben), 32'd0);
      chk("midrst_full", cyc, 32'(full), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1;
      mq.delete();
      m_drain  = 0;
      m_starve = 0;
      repeat (10) do_cycle(1, 0, 0);
      repeat (20) do_cycle(1, $urandom_range(0, 1) == 1, 1);
      repeat (30) do_cycle(1, 0, 0);

      @(negedge clk);
      #1;
      chk("sb_drained", cyc, 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
